conv5_wm_loader: RTL

CONV5_WM_LOADER -- requirements
Module: conv5_wm_loader

---
 rtl/conv5_wm_loader_pkg.sv | 27 ++
 rtl/conv5_wm_pack.sv | 55 +++++
 rtl/conv5_wm_loader.sv | 110 +++++++++++
 3 files changed

// File: rtl/conv5_wm_loader_pkg.sv
// Shared definitions for the conv5 weight-memory loader: FSM state type,
// conv5 weight geometry and the beats-per-line derivation.
package conv5_wm_loader_pkg;

  localparam int unsigned CONV5_DIN_WIDTH  = 64;
  localparam int unsigned CONV5_LINE_WIDTH = 512;
  localparam int unsigned CONV5_DEPTH      = 864;
  localparam int unsigned CONV5_ADDR_WIDTH = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  function automatic int unsigned beats_per_line(input int unsigned line_w,
                                                 input int unsigned din_w);
    return line_w / din_w;
  endfunction

  // Counter width that stays legal (>= 1 bit) when only one beat fills a line.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned CONV5_R = beats_per_line(CONV5_LINE_WIDTH, CONV5_DIN_WIDTH);

endpackage

// File: rtl/conv5_wm_pack.sv
// Packs DIN_WIDTH beats little-endian into one LINE_WIDTH line and strobes
// line_done_o on the beat that completes it; line_o includes that beat.
module conv5_wm_pack
  import conv5_wm_loader_pkg::*;
#(
  parameter int unsigned DIN_WIDTH  = CONV5_DIN_WIDTH,
  parameter int unsigned LINE_WIDTH = CONV5_LINE_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  beat_i,
  input  logic [DIN_WIDTH-1:0]  din_i,
  output logic [LINE_WIDTH-1:0] line_o,
  output logic                  line_done_o
);

  localparam int unsigned R      = beats_per_line(LINE_WIDTH, DIN_WIDTH);
  localparam int unsigned BEAT_W = cnt_width(R);

  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic                  last_beat;

  assign last_beat = (beat_cnt_q == BEAT_W'(R - 1));

  always_comb begin
    line_d     = line_q;
    beat_cnt_d = beat_cnt_q;
    if (clr_i) begin
      beat_cnt_d = '0;
    end else if (beat_i) begin
      for (int unsigned k = 0; k < R; k++) begin
        if (beat_cnt_q == BEAT_W'(k)) begin
          line_d[k*DIN_WIDTH +: DIN_WIDTH] = din_i;
        end
      end
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt_q <= '0;
      line_q     <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      line_q     <= line_d;
    end
  end

  assign line_o      = line_d;
  assign line_done_o = beat_i && !clr_i && last_beat;

endmodule

// File: rtl/conv5_wm_loader.sv
// Streams conv5 weights into the weight RAM: packs input beats into lines,
// writes DEPTH lines from address 0 and pulses done with the final write.
module conv5_wm_loader
  import conv5_wm_loader_pkg::*;
#(
  parameter int unsigned DIN_WIDTH  = CONV5_DIN_WIDTH,
  parameter int unsigned LINE_WIDTH = CONV5_LINE_WIDTH,
  parameter int unsigned DEPTH      = CONV5_DEPTH,
  parameter int unsigned ADDR_WIDTH = CONV5_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [DIN_WIDTH-1:0]  din,
  output logic                  wea,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [LINE_WIDTH-1:0] dina,
  output logic                  busy,
  output logic                  done
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] line_cnt_q, line_cnt_d;
  logic                  wea_q, wea_d;
  logic [ADDR_WIDTH-1:0] addra_q, addra_d;
  logic [LINE_WIDTH-1:0] dina_q, dina_d;
  logic                  done_q, done_d;

  logic                  accept;
  logic                  pack_clr;
  logic                  line_done;
  logic [LINE_WIDTH-1:0] pack_line;

  assign accept = (state_q == ST_LOAD) && din_valid;

  conv5_wm_pack #(
    .DIN_WIDTH  (DIN_WIDTH),
    .LINE_WIDTH (LINE_WIDTH)
  ) u_pack (
    .clk_i       (clk),
    .rst_i       (rst),
    .clr_i       (pack_clr),
    .beat_i      (accept),
    .din_i       (din),
    .line_o      (pack_line),
    .line_done_o (line_done)
  );

  // dina is captured here while the packer keeps filling the next line.
  always_comb begin
    state_d    = state_q;
    line_cnt_d = line_cnt_q;
    wea_d      = 1'b0;
    done_d     = 1'b0;
    addra_d    = addra_q;
    dina_d     = dina_q;
    pack_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          line_cnt_d = '0;
          pack_clr   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (line_done) begin
          wea_d   = 1'b1;
          addra_d = line_cnt_q;
          dina_d  = pack_line;
          if (line_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            line_cnt_d = line_cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      line_cnt_q <= '0;
      wea_q      <= 1'b0;
      addra_q    <= '0;
      dina_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_cnt_q <= line_cnt_d;
      wea_q      <= wea_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
      done_q     <= done_d;
    end
  end

  assign din_ready = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_LOAD);
  assign wea       = wea_q;
  assign addra     = addra_q;
  assign dina      = dina_q;
  assign done      = done_q;

endmodule
